// File: rtl/parity_guard_unit.sv
// Single-bit parity guard for SRAM-style storage: combinational encode/check
// datapaths plus a sticky error flag and saturating error counter.
module parity_guard_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ODD_PARITY = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] enc_data_in,
  output logic [DATA_WIDTH:0]   enc_coded_out,
  input  logic [DATA_WIDTH:0]   chk_coded_in,
  input  logic                  chk_valid,
  output logic [DATA_WIDTH-1:0] chk_data_out,
  output logic                  chk_error,
  input  logic                  err_clear,
  output logic                  err_sticky,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic ODD_BIT = (ODD_PARITY != 0);

  // Running XOR chains; seeding with ODD_BIT folds the parity sense in once.
  logic [DATA_WIDTH:0]   enc_chain;
  logic [DATA_WIDTH+1:0] chk_chain;

  assign enc_chain[0] = ODD_BIT;
  assign chk_chain[0] = ODD_BIT;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_enc_xor
      assign enc_chain[gi+1] = enc_chain[gi] ^ enc_data_in[gi];
    end
    for (genvar gi = 0; gi <= DATA_WIDTH; gi++) begin : g_chk_xor
      assign chk_chain[gi+1] = chk_chain[gi] ^ chk_coded_in[gi];
    end
  endgenerate

  logic enc_parity;
  logic chk_syndrome;

  assign enc_parity    = enc_chain[DATA_WIDTH];
  assign enc_coded_out = {enc_data_in, enc_parity};

  assign chk_syndrome = chk_chain[DATA_WIDTH+1];
  assign chk_error    = chk_syndrome & chk_valid;
  assign chk_data_out = chk_coded_in[DATA_WIDTH:1];

  logic                 err_sticky_reg;
  logic                 err_sticky_next;
  logic [CNT_WIDTH-1:0] err_count_reg;
  logic [CNT_WIDTH-1:0] err_count_next;

  // Clear wins over a coincident error; the counter holds at all-ones.
  always_comb begin
    err_sticky_next = err_sticky_reg;
    err_count_next  = err_count_reg;
    if (err_clear) begin
      err_sticky_next = 1'b0;
      err_count_next  = '0;
    end else if (chk_error) begin
      err_sticky_next = 1'b1;
      if (err_count_reg != {CNT_WIDTH{1'b1}}) begin
        err_count_next = err_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sticky_reg <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      err_sticky_reg <= err_sticky_next;
      err_count_reg  <= err_count_next;
    end
  end

  assign err_sticky = err_sticky_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_parity_guard_unit.sv
// Bench for parity_guard_unit: three instances (even/CNT8, even/CNT4, odd/CNT8)
// share stimulus; a counting-based reference model predicts every output.
module tb_parity_guard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] enc_in;
  logic [32:0] coded;
  logic        valid;
  logic        clear;

  logic [32:0] enc_o0, enc_o1, enc_o2;
  logic [31:0] data_o0, data_o1, data_o2;
  logic        err_o0, err_o1, err_o2;
  logic        st_o0, st_o1, st_o2;
  logic [7:0]  cnt_o0;
  logic [3:0]  cnt_o1;
  logic [7:0]  cnt_o2;

  parity_guard_unit #(.DATA_WIDTH(32), .ODD_PARITY(0), .CNT_WIDTH(8)) u0 (
    .clk(clk), .reset(reset), .enc_data_in(enc_in), .enc_coded_out(enc_o0),
    .chk_coded_in(coded), .chk_valid(valid), .chk_data_out(data_o0),
    .chk_error(err_o0), .err_clear(clear), .err_sticky(st_o0), .err_count(cnt_o0));

  parity_guard_unit #(.DATA_WIDTH(32), .ODD_PARITY(0), .CNT_WIDTH(4)) u1 (
    .clk(clk), .reset(reset), .enc_data_in(enc_in), .enc_coded_out(enc_o1),
    .chk_coded_in(coded), .chk_valid(valid), .chk_data_out(data_o1),
    .chk_error(err_o1), .err_clear(clear), .err_sticky(st_o1), .err_count(cnt_o1));

  parity_guard_unit #(.DATA_WIDTH(32), .ODD_PARITY(1), .CNT_WIDTH(8)) u2 (
    .clk(clk), .reset(reset), .enc_data_in(enc_in), .enc_coded_out(enc_o2),
    .chk_coded_in(coded), .chk_valid(valid), .chk_data_out(data_o2),
    .chk_error(err_o2), .err_clear(clear), .err_sticky(st_o2), .err_count(cnt_o2));

  int errors = 0;
  int checks = 0;

  int odd_of [3] = '{0, 0, 1};
  int cw_of  [3] = '{8, 4, 8};
  int m_cnt  [3];
  bit m_sticky [3];

  typedef struct {
    logic [31:0] enc_in;
    logic [32:0] coded;
    logic        valid;
    logic        clear;
    logic [32:0] exp_enc;
    logic        exp_err;
    logic [31:0] exp_data;
    logic        exp_sticky;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] m_enc(int i, logic [31:0] d);
    return {d, 1'(($countones(d) + odd_of[i]) % 2)};
  endfunction

  function automatic logic m_err(int i);
    return valid && ((($countones(coded) + odd_of[i]) % 2) == 1);
  endfunction

  task automatic check_model(string tag);
    logic [32:0] e;
    logic [31:0] d;
    logic        er;
    logic        s;
    logic [7:0]  c;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin e = enc_o0; d = data_o0; er = err_o0; s = st_o0; c = cnt_o0; end
        1:       begin e = enc_o1; d = data_o1; er = err_o1; s = st_o1; c = {4'd0, cnt_o1}; end
        default: begin e = enc_o2; d = data_o2; er = err_o2; s = st_o2; c = cnt_o2; end
      endcase
      check($sformatf("%s.u%0d.enc", tag, i), 64'(e), 64'(m_enc(i, enc_in)));
      check($sformatf("%s.u%0d.data", tag, i), 64'(d), 64'(coded[32:1]));
      check($sformatf("%s.u%0d.err", tag, i), 64'(er), 64'(m_err(i)));
      check($sformatf("%s.u%0d.sticky", tag, i), 64'(s), 64'(m_sticky[i]));
      check($sformatf("%s.u%0d.cnt", tag, i), 64'(c), 64'(m_cnt[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]    = 0;
      m_sticky[i] = 1'b0;
    end
  endtask

  task automatic apply(string tag, logic [31:0] e, logic [32:0] c, logic v, logic cl);
    enc_in = e;
    coded  = c;
    valid  = v;
    clear  = cl;
    #1;
    check_model({tag, ".pre"});
  endtask

  task automatic clock_it(string tag);
    bit hit [3];
    for (int i = 0; i < 3; i++) hit[i] = m_err(i);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        m_cnt[i]    = 0;
        m_sticky[i] = 1'b0;
      end else if (hit[i]) begin
        m_sticky[i] = 1'b1;
        if (m_cnt[i] < (1 << cw_of[i]) - 1) m_cnt[i]++;
      end
    end
    #1;
    check_model({tag, ".post"});
  endtask

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 33'h000000003, 1'b1, 1'b0, 33'h1FFFFFFFE, 1'b0, 32'h00000001, 1'b0, 8'd0};
    vecs[1] = '{32'h00000001, 33'h000000002, 1'b1, 1'b0, 33'h000000003, 1'b1, 32'h00000001, 1'b1, 8'd1};
    vecs[2] = '{32'h00000000, 33'h000000005, 1'b1, 1'b0, 33'h000000000, 1'b0, 32'h00000002, 1'b1, 8'd1};
    for (int k = 3; k < 8; k++)
      vecs[k] = '{32'h00000001, 33'h000000002, 1'b0, 1'b0, 33'h000000003, 1'b0, 32'h00000001, 1'b1, 8'd1};
    vecs[8] = '{32'h80000000, 33'h100000000, 1'b1, 1'b0, 33'h100000001, 1'b1, 32'h80000000, 1'b1, 8'd2};
    vecs[9] = '{32'h00000000, 33'h000000002, 1'b1, 1'b1, 33'h000000000, 1'b1, 32'h00000001, 1'b0, 8'd0};

    reset  = 1'b0;
    enc_in = '0;
    coded  = '0;
    valid  = 1'b0;
    clear  = 1'b0;
    model_reset();
    #2;
    check_model("reset");
    check("reset.sticky", 64'(st_o0), 64'd0);
    check("reset.cnt", 64'(cnt_o0), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int k = 0; k < 10; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      apply(tag, vecs[k].enc_in, vecs[k].coded, vecs[k].valid, vecs[k].clear);
      check({tag, ".enc"}, 64'(enc_o0), 64'(vecs[k].exp_enc));
      check({tag, ".err"}, 64'(err_o0), 64'(vecs[k].exp_err));
      check({tag, ".data"}, 64'(data_o0), 64'(vecs[k].exp_data));
      clock_it(tag);
      check({tag, ".sticky"}, 64'(st_o0), 64'(vecs[k].exp_sticky));
      check({tag, ".cnt"}, 64'(cnt_o0), 64'(vecs[k].exp_cnt));
      $display("vec%0d enc_in=%h coded=%h valid=%b clear=%b -> err=%b cnt=%0d", k,
               vecs[k].enc_in, vecs[k].coded, vecs[k].valid, vecs[k].clear, err_o0, cnt_o0);
    end

    // Saturation on the 4-bit counter, then clear racing an error.
    for (int k = 0; k < 20; k++) begin
      apply("sat", 32'h0, 33'h000000002, 1'b1, 1'b0);
      clock_it("sat");
    end
    check("sat.cnt4", 64'(cnt_o1), 64'd15);
    check("sat.cnt8", 64'(cnt_o0), 64'd20);
    apply("satclr", 32'h0, 33'h000000002, 1'b1, 1'b1);
    check("satclr.err", 64'(err_o1), 64'd1);
    clock_it("satclr");
    check("satclr.cnt4", 64'(cnt_o1), 64'd0);
    check("satclr.sticky4", 64'(st_o1), 64'd0);
    $display("saturation: cnt4 reached 15 then cleared -> cnt4=%0d sticky=%b", cnt_o1, st_o1);

    // Asynchronous reset between clock edges.
    for (int k = 0; k < 3; k++) begin
      apply("pre_rst", 32'h0, 33'h000000002, 1'b1, 1'b0);
      clock_it("pre_rst");
    end
    check("pre_rst.cnt", 64'(cnt_o0), 64'd3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst.cnt", 64'(cnt_o0), 64'd0);
    check("async_rst.sticky", 64'(st_o0), 64'd0);
    check_model("async_rst");
    $display("async reset mid-cycle -> cnt=%0d sticky=%b", cnt_o0, st_o0);
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_model("rst_release");

    // Odd parity instance.
    apply("odd", 32'h00000000, 33'h000000001, 1'b1, 1'b0);
    check("odd.enc", 64'(enc_o2), 64'h1);
    check("odd.err", 64'(err_o2), 64'd0);
    clock_it("odd");
    $display("odd parity: enc(0)=%h chk_error=%b", enc_o2, err_o2);

    // Random traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      logic [32:0] c;
      c = {1'($urandom), 32'($urandom)};
      apply("rand", 32'($urandom), c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      clock_it("rand");
    end
    $display("random: 300 cycles done, cnt0=%0d cnt1=%0d cnt2=%0d", cnt_o0, cnt_o1, cnt_o2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_guard_unit.md
Name: parity_guard_unit

Overview:
- Single-bit parity protection block for SRAM-style storage arrays.
- Encode path appends one parity bit to write data. Check path strips the parity bit from stored coded words and flags mismatches.
- Registered status (sticky error flag, saturating error counter) feeds higher-level error reporting.
- Encode and check datapaths are purely combinational, so they can sit directly on an SRAM's write and read ports.

Parameters:
- DATA_WIDTH, 32, number of payload bits per word (≥1).
- ODD_PARITY, 0, 0 = even parity (parity bit = XOR of data bits); 1 = odd parity (inverted XOR).
- CNT_WIDTH, 8, width of the saturating error counter (≥1).

Ports:
- clk  input  1  clock; all registers update on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enc_data_in  input  DATA_WIDTH  payload to encode.
- enc_coded_out  output  DATA_WIDTH+1  coded word: [DATA_WIDTH:1] = enc_data_in, [0] = parity bit.
- chk_coded_in  input  DATA_WIDTH+1  coded word to check, same layout as enc_coded_out.
- chk_valid  input  1  qualifies chk_coded_in (read enable).
- chk_data_out  output  DATA_WIDTH  chk_coded_in[DATA_WIDTH:1], passed through uncorrected.
- chk_error  output  1  combinational parity mismatch, qualified by chk_valid.
- err_clear  input  1  synchronous clear of err_sticky and err_count.
- err_sticky  output  1  registered; set by any qualified error.
- err_count  output  CNT_WIDTH  registered saturating count of qualified errors.

Behaviour:
- Encoder (combinational, zero latency):
  - p = XOR-reduce(enc_data_in) XOR ODD_PARITY.
  - enc_coded_out = {enc_data_in, p}.
- Checker (combinational, zero latency):
  - syndrome = XOR-reduce(chk_coded_in) XOR ODD_PARITY.
  - raw_err = syndrome.
  - chk_error = raw_err & chk_valid.
  - chk_data_out is always the data field, whether or not chk_valid is asserted and whether or not an error is detected. No correction is performed.
- Detection limits: any odd number of flipped bits (data or parity) is detected. Even numbers of flips go undetected; this is the required behaviour and is not an error.
- Status registers:
  - Reset (reset=0, asynchronous): err_sticky=0, err_count=0. Reset asserted mid-operation clears both immediately, independent of clk.
  - Each rising clk with reset=1:
    - If err_clear=1: err_sticky←0 and err_count←0. Clear has priority over a simultaneous chk_error.
    - Else if chk_error=1: err_sticky←1, and err_count←err_count+1 unless already all-ones (saturates, never wraps).
    - Else: both hold.
- chk_valid=0 never changes status, even if raw_err=1.
- Combinational outputs have no reset dependency. They follow their inputs during reset.

Test Plan:
- Encode, DATA_WIDTH=32, even: enc_data_in=0xFFFFFFFF -> enc_coded_out=33'h1FFFFFFFE. enc_data_in=0x00000001 -> 33'h000000003.
- Clean check: chk_coded_in=33'h000000003, chk_valid=1 -> chk_error=0, chk_data_out=0x00000001; err_count stays 0 after the clock edge.
- Single-bit fault: chk_coded_in=33'h000000002, chk_valid=1 -> chk_error=1, chk_data_out=0x00000001. After the clock edge: err_sticky=1, err_count=1. A two-bit fault, 33'h000000005, -> chk_error=0.
- Qualification: faulty word 33'h000000002 with chk_valid=0 for 5 cycles -> chk_error=0; err_sticky and err_count unchanged.
- Saturation and clear, CNT_WIDTH=4: 20 consecutive qualified errors -> err_count=15. Then err_clear=1 together with chk_error=1 for one cycle -> err_count=0, err_sticky=0.
- Async reset and odd parity: with err_count=3, drive reset=0 between clock edges -> err_count=0 and err_sticky=0 immediately. With ODD_PARITY=1: enc_data_in=0x00000000 -> enc_coded_out=33'h000000001; checking that word -> chk_error=0.
